// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: dispatch, entry, issue and bypass buses.
package alu_issue_queue_pkg;

  localparam int unsigned IQ_DEPTH    = 8;
  localparam int unsigned IQ_N_BYPASS = 4;
  localparam int unsigned TAG_W       = 6;

  typedef logic [TAG_W-1:0] phy_tag_t;

  typedef struct packed {
    logic [31:0] inst;
    phy_tag_t    phy_dest;
    phy_tag_t    src1_tag;
    phy_tag_t    src2_tag;
    logic        src1_ready;
    logic        src2_ready;
    logic [31:0] src1_value;
    logic [31:0] src2_value;
    logic [4:0]  rob_entry_num;
  } dispatch_to_issue_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    phy_tag_t    phy_dest;
    phy_tag_t    src1_tag;
    phy_tag_t    src2_tag;
    logic        src1_ready;
    logic        src2_ready;
    logic [31:0] src1_value;
    logic [31:0] src2_value;
    logic [4:0]  rob_entry_num;
  } iq_entry_t;

  typedef struct packed {
    logic [31:0] inst;
    phy_tag_t    phy_dest;
    logic [31:0] src1_value;
    logic [31:0] src2_value;
    logic [4:0]  rob_entry_num;
  } issue_to_execute_bus_t;

  typedef struct packed {
    logic [3:0]  rf_we;
    phy_tag_t    phy_dest;
    logic [31:0] result;
  } bypass_bus_t;

  // Only rf_we[0] marks a register-file write that can wake a waiting source.
  function automatic logic bypass_hit(bypass_bus_t b, phy_tag_t tag);
    return b.rf_we[0] && (b.phy_dest == tag);
  endfunction

endpackage

// File: rtl/alu_issue_queue_oldest_select.sv
// Oldest-ready picker: grants the requester with no older requester in the age matrix.
module iq_oldest_select #(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0] req_i,
  input  logic [DEPTH-1:0] age_i [DEPTH],
  output logic [DEPTH-1:0] grant_o,
  output logic             grant_valid_o
);

  // age_i[i][j] = 1 means entry j is older than entry i.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      grant_o[i] = req_i[i] && ((req_i & age_i[i]) == '0);
    end
  end

  assign grant_valid_o = |req_i;

endmodule

// File: rtl/alu_issue_queue.sv
// Out-of-order ALU issue queue: operand capture from bypass buses and oldest-ready issue.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = IQ_DEPTH,
  parameter int unsigned N_BYPASS = IQ_N_BYPASS
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   dispatch_valid,
  output logic                   iq_allowin,
  input  dispatch_to_issue_bus_t dispatch_inst,
  input  bypass_bus_t            bypass_bus [N_BYPASS],
  input  logic                   alu_allowin,
  output logic                   issue_to_alu_valid,
  output issue_to_execute_bus_t  issue_inst
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  iq_entry_t        entry_q [DEPTH];
  iq_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] age_q   [DEPTH];
  logic [DEPTH-1:0] age_d   [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] req, grant;
  logic             grant_valid;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic             dispatch_fire, issue_fire;
  iq_entry_t        new_entry;

  assign iq_allowin         = (count_q != CNT_W'(DEPTH));
  assign dispatch_fire      = dispatch_valid && iq_allowin && free_found;
  assign issue_to_alu_valid = grant_valid && !flush;
  assign issue_fire         = issue_to_alu_valid && alu_allowin;

  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      req[e] = entry_q[e].valid && entry_q[e].src1_ready && entry_q[e].src2_ready;
    end
  end

  iq_oldest_select #(.DEPTH(DEPTH)) u_select (
    .req_i         (req),
    .age_i         (age_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!free_found && !entry_q[i].valid) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  // Incoming op: same-cycle bypass capture (lowest k first), then r0 forced ready/zero.
  always_comb begin
    new_entry               = '0;
    new_entry.valid         = 1'b1;
    new_entry.inst          = dispatch_inst.inst;
    new_entry.phy_dest      = dispatch_inst.phy_dest;
    new_entry.src1_tag      = dispatch_inst.src1_tag;
    new_entry.src2_tag      = dispatch_inst.src2_tag;
    new_entry.src1_ready    = dispatch_inst.src1_ready;
    new_entry.src2_ready    = dispatch_inst.src2_ready;
    new_entry.src1_value    = dispatch_inst.src1_value;
    new_entry.src2_value    = dispatch_inst.src2_value;
    new_entry.rob_entry_num = dispatch_inst.rob_entry_num;
    for (int unsigned k = 0; k < N_BYPASS; k++) begin
      if (!new_entry.src1_ready && bypass_hit(bypass_bus[k], dispatch_inst.src1_tag)) begin
        new_entry.src1_ready = 1'b1;
        new_entry.src1_value = bypass_bus[k].result;
      end
      if (!new_entry.src2_ready && bypass_hit(bypass_bus[k], dispatch_inst.src2_tag)) begin
        new_entry.src2_ready = 1'b1;
        new_entry.src2_value = bypass_bus[k].result;
      end
    end
    if (dispatch_inst.src1_tag == '0) begin
      new_entry.src1_ready = 1'b1;
      new_entry.src1_value = '0;
    end
    if (dispatch_inst.src2_tag == '0) begin
      new_entry.src2_ready = 1'b1;
      new_entry.src2_value = '0;
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
    for (int unsigned e = 0; e < DEPTH; e++) begin
      entry_d[e] = entry_q[e];
      age_d[e]   = age_q[e];
    end
    // Wakeup: once a source turns ready, higher-k buses are ignored (lowest k wins).
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (entry_q[e].valid) begin
        for (int unsigned k = 0; k < N_BYPASS; k++) begin
          if (!entry_d[e].src1_ready && bypass_hit(bypass_bus[k], entry_q[e].src1_tag)) begin
            entry_d[e].src1_ready = 1'b1;
            entry_d[e].src1_value = bypass_bus[k].result;
          end
          if (!entry_d[e].src2_ready && bypass_hit(bypass_bus[k], entry_q[e].src2_tag)) begin
            entry_d[e].src2_ready = 1'b1;
            entry_d[e].src2_value = bypass_bus[k].result;
          end
        end
      end
    end
    if (issue_fire) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (grant[e]) begin
          entry_d[e].valid = 1'b0;
          age_d[e]         = '0;
          for (int unsigned i = 0; i < DEPTH; i++) age_d[i][e] = 1'b0;
        end
      end
    end
    // Age row is built from post-issue validity, before the new entry is written.
    if (dispatch_fire) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        age_d[free_idx][j] = entry_d[j].valid && (IDX_W'(j) != free_idx);
        age_d[j][free_idx] = 1'b0;
      end
      entry_d[free_idx] = new_entry;
    end
    if (flush) begin
      count_d = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        entry_d[e] = '0;
        age_d[e]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        entry_q[e] <= '0;
        age_q[e]   <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        entry_q[e] <= entry_d[e];
        age_q[e]   <= age_d[e];
      end
    end
  end

  always_comb begin
    issue_inst = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (grant[e]) begin
        issue_inst.inst          = entry_q[e].inst;
        issue_inst.phy_dest      = entry_q[e].phy_dest;
        issue_inst.src1_value    = entry_q[e].src1_value;
        issue_inst.src2_value    = entry_q[e].src2_value;
        issue_inst.rob_entry_num = entry_q[e].rob_entry_num;
      end
    end
  end

endmodule
